// File: rtl/key_click_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_click_decoder_pkg
// Purpose  : Shared constants for the key front end: state encodings of the
//            click decoder and default window lengths for a 50 MHz clock,
//            plus short simulation windows.
// Revision : 1.0 - initial release
// ============================================================================
package key_click_decoder_pkg;

    // Click decoder state encodings
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_wait2 = 1'b1;

    // Last timer count of each window at 50 MHz
    localparam int unsigned c_win_max_50mhz      = 14_999_999; // 300 ms
    localparam int unsigned c_debounce_max_50mhz = 999_999;    // 20 ms

    // Short windows for simulation
    localparam int unsigned c_win_max_sim      = 9;
    localparam int unsigned c_debounce_max_sim = 4;

endpackage : key_click_decoder_pkg
`default_nettype wire

// File: rtl/key_click_decoder.sv
`default_nettype none
// ============================================================================
// Module   : key_click_decoder
// Purpose  : Sorts debounced one-cycle key presses into single and double
//            clicks using a fixed window, and keeps a wrapping mode counter
//            (+1 per single click, -1 per double click).
// Ports    : clk          - system clock
//            rst          - asynchronous active-high reset
//            key_flag     - debounced press pulse, one cycle wide
//            single_click - one-cycle pulse, press with no follow-up in window
//            double_click - one-cycle pulse, second press inside window
//            busy         - high while a window is open
//            mode         - wrapping mode counter
// Revision : 1.0 - initial release
// ============================================================================
module key_click_decoder
    import key_click_decoder_pkg::*;
#(
    parameter int unsigned WIN_MAX = c_win_max_50mhz,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned MODE_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_flag,
    output logic              single_click,
    output logic              double_click,
    output logic              busy,
    output logic [MODE_W-1:0] mode
);

    localparam logic [CNT_W-1:0] c_win_max = CNT_W'(WIN_MAX);

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_timer;
    logic              r_single;
    logic              r_double;
    logic              r_busy;
    logic [MODE_W-1:0] r_mode;

    logic [0:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_timer_nxt;
    logic              w_single_nxt;
    logic              w_double_nxt;
    logic [MODE_W-1:0] w_mode_nxt;

    // Next-state and next-output logic. A press in WAIT2 is checked before
    // the window expiry so that a press on the last count is a double click.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_single_nxt = 1'b0;
        w_double_nxt = 1'b0;
        w_mode_nxt   = r_mode;
        case (r_state)
            c_st_idle: begin
                if (key_flag) begin
                    w_state_nxt = c_st_wait2;
                    w_timer_nxt = '0;
                end
            end
            c_st_wait2: begin
                if (key_flag) begin
                    w_state_nxt  = c_st_idle;
                    w_timer_nxt  = '0;
                    w_double_nxt = 1'b1;
                    w_mode_nxt   = r_mode - MODE_W'(1);
                end else if (r_timer == c_win_max) begin
                    w_state_nxt  = c_st_idle;
                    w_timer_nxt  = '0;
                    w_single_nxt = 1'b1;
                    w_mode_nxt   = r_mode + MODE_W'(1);
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_timer  <= '0;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_busy   <= 1'b0;
            r_mode   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_single <= w_single_nxt;
            r_double <= w_double_nxt;
            r_busy   <= (w_state_nxt == c_st_wait2);
            r_mode   <= w_mode_nxt;
        end
    end

    assign single_click = r_single;
    assign double_click = r_double;
    assign busy         = r_busy;
    assign mode         = r_mode;

endmodule : key_click_decoder
`default_nettype wire

// File: tb/tb_key_click_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_click_decoder
// Purpose  : Self-checking bench for key_click_decoder with a short window
//            (WIN_MAX=9) and a 2-bit mode counter. Expected outputs come from
//            a press-timeline model: a window opens at the edge of a press and
//            resolves either on the next press or WIN_MAX+1 edges later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_click_decoder;

    localparam int unsigned WIN_MAX = 9;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned MODE_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              key_flag = 1'b0;
    logic              single_click;
    logic              double_click;
    logic              busy;
    logic [MODE_W-1:0] mode;

    int total = 0;
    int bad   = 0;

    // Reference model: edge counter and the edge at which the open window began
    int          m_edge      = 0;
    bit          m_open      = 1'b0;
    int          m_open_edge = 0;
    logic        exp_single  = 1'b0;
    logic        exp_double  = 1'b0;
    logic        exp_busy    = 1'b0;
    logic [MODE_W-1:0] exp_mode = '0;

    key_click_decoder #(
        .WIN_MAX (WIN_MAX),
        .CNT_W   (CNT_W),
        .MODE_W  (MODE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_flag     (key_flag),
        .single_click (single_click),
        .double_click (double_click),
        .busy         (busy),
        .mode         (mode)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_open     = 1'b0;
        exp_single = 1'b0;
        exp_double = 1'b0;
        exp_busy   = 1'b0;
        exp_mode   = '0;
    endtask

    // Advance the model by one clock edge on which press p was sampled
    task automatic model_step(input bit p);
        exp_single = 1'b0;
        exp_double = 1'b0;
        if (m_open) begin
            if (p) begin
                exp_double = 1'b1;
                m_open     = 1'b0;
                exp_mode   = exp_mode - 1'b1;
            end else if (m_edge - m_open_edge == int'(WIN_MAX) + 1) begin
                exp_single = 1'b1;
                m_open     = 1'b0;
                exp_mode   = exp_mode + 1'b1;
            end
        end else if (p) begin
            m_open      = 1'b1;
            m_open_edge = m_edge;
        end
        exp_busy = m_open;
        m_edge++;
    endtask

    // Present p, let one edge sample it, update the model and settle
    task automatic cycle(input bit p);
        key_flag = p;
        @(posedge clk);
        model_step(p);
        #1;
        key_flag = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0);
            total++;
            if ({single_click, double_click, busy, mode} !== 5'b0) begin
                bad++;
                $display("FAIL reset_state cyc=%0d got s=%b d=%b b=%b m=%0d want all 0",
                         c, single_click, double_click, busy, mode);
            end
        end
    endtask

    task automatic test_single();
        int n_single = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            cycle(c == 0);
            total++;
            if ({single_click, double_click, busy, mode} !== {exp_single, exp_double, exp_busy, exp_mode}) begin
                bad++;
                $display("FAIL single cyc=%0d got s=%b d=%b b=%b m=%0d want s=%b d=%b b=%b m=%0d",
                         c, single_click, double_click, busy, mode,
                         exp_single, exp_double, exp_busy, exp_mode);
            end
            if (single_click === 1'b1) n_single++;
        end
        total++;
        if (n_single != 1 || mode !== 2'd1) begin
            bad++;
            $display("FAIL single_summary got singles=%0d mode=%0d want 1 and 1", n_single, mode);
        end
    endtask

    task automatic test_double();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            cycle(c == 0 || c == 5);
            total++;
            if ({single_click, double_click, busy, mode} !== {exp_single, exp_double, exp_busy, exp_mode}) begin
                bad++;
                $display("FAIL double cyc=%0d got s=%b d=%b b=%b m=%0d want s=%b d=%b b=%b m=%0d",
                         c, single_click, double_click, busy, mode,
                         exp_single, exp_double, exp_busy, exp_mode);
            end
        end
        total++;
        if (mode !== 2'd3) begin
            bad++;
            $display("FAIL double_wrap got mode=%0d want 3", mode);
        end
    endtask

    // Second press on the very last count of the window still counts as double
    task automatic test_boundary();
        int n_double = 0;
        int n_single = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            cycle(c == 0 || c == 10);
            total++;
            if ({single_click, double_click, busy, mode} !== {exp_single, exp_double, exp_busy, exp_mode}) begin
                bad++;
                $display("FAIL boundary cyc=%0d got s=%b d=%b b=%b m=%0d want s=%b d=%b b=%b m=%0d",
                         c, single_click, double_click, busy, mode,
                         exp_single, exp_double, exp_busy, exp_mode);
            end
            if (double_click === 1'b1) n_double++;
            if (single_click === 1'b1) n_single++;
        end
        total++;
        if (n_double != 1 || n_single != 0) begin
            bad++;
            $display("FAIL boundary_summary got doubles=%0d singles=%0d want 1 and 0", n_double, n_single);
        end
    endtask

    // Press just after the window closes opens a fresh window
    task automatic test_back_to_back();
        int n_single = 0;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            cycle(c == 0 || c == 11);
            total++;
            if ({single_click, double_click, busy, mode} !== {exp_single, exp_double, exp_busy, exp_mode}) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got s=%b d=%b b=%b m=%0d want s=%b d=%b b=%b m=%0d",
                         c, single_click, double_click, busy, mode,
                         exp_single, exp_double, exp_busy, exp_mode);
            end
            if (single_click === 1'b1) n_single++;
        end
        total++;
        if (n_single != 2 || mode !== 2'd2) begin
            bad++;
            $display("FAIL back_to_back_summary got singles=%0d mode=%0d want 2 and 2", n_single, mode);
        end
    endtask

    task automatic test_reset_mid_window();
        do_reset();
        for (int c = 0; c < 11; c++) cycle(c == 0);   // one single click, mode=1
        for (int c = 0; c < 4; c++) cycle(c == 0);    // open a window, then abort it
        rst = 1'b1;
        #1;
        total++;
        if ({single_click, double_click, busy, mode} !== 5'b0) begin
            bad++;
            $display("FAIL async_reset got s=%b d=%b b=%b m=%0d want all 0",
                     single_click, double_click, busy, mode);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 15; c++) begin
            cycle(1'b0);
            total++;
            if ({single_click, double_click, busy, mode} !== 5'b0) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got s=%b d=%b b=%b m=%0d want all 0",
                         c, single_click, double_click, busy, mode);
            end
        end
    endtask

    task automatic test_random();
        bit p;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            p = ($urandom_range(0, 7) == 0);
            cycle(p);
            total++;
            if ({single_click, double_click, busy, mode} !== {exp_single, exp_double, exp_busy, exp_mode}) begin
                bad++;
                $display("FAIL random cyc=%0d got s=%b d=%b b=%b m=%0d want s=%b d=%b b=%b m=%0d",
                         c, single_click, double_click, busy, mode,
                         exp_single, exp_double, exp_busy, exp_mode);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_double();
        test_boundary();
        test_back_to_back();
        test_reset_mid_window();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_key_click_decoder
`default_nettype wire
